// File: rtl/emmc_cmd_ctrl.sv
// eMMC CMD-line controller: sends a 48-bit command frame with CRC7, then receives and checks the card response under NCR/NCC timing.
// Optional build macro EMMC_CMD_R2_EN enables 136-bit R2 receive; without it resp_type 3 is handled as R1.
module emmc_cmd_ctrl #(
  parameter int NCR_MAX = 64,
  parameter int NCC_MIN = 8
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_argument,
  input  logic [1:0]   resp_type,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  output logic         resp_valid,
  output logic [5:0]   resp_index,
  output logic [127:0] resp_data,
  output logic [2:0]   status,
  output logic         busy
);

`ifdef EMMC_CMD_R2_EN
  localparam int RX_W = 136;
  localparam int RD_W = 128;
`else
  localparam int RX_W = 48;
  localparam int RD_W = 32;
`endif
  localparam int CNT_A = (NCR_MAX > RX_W) ? NCR_MAX : RX_W;
  localparam int CNT_MAX = (NCC_MIN > CNT_A) ? NCC_MIN : CNT_A;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [2:0] IDLE_GUARD = 3'd0;
  localparam logic [2:0] IDLE       = 3'd1;
  localparam logic [2:0] SEND       = 3'd2;
  localparam logic [2:0] NCR_WAIT   = 3'd3;
  localparam logic [2:0] RECV       = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;
  localparam logic [2:0] NCC        = 3'd6;

  // CRC7, generator x^7 + x^3 + 1, MSB-first, seed 0.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] crc;
    crc = '0;
    for (int i = 39; i >= 0; i--) crc = crc7_step(crc, bits[i]);
    return crc;
  endfunction

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        rtype;
  logic [46:0]       tx_sr;
  logic [RX_W-2:0]   rx_sr;
  logic [RX_W-1:0]   rx_next;
  logic [39:0]       tx_head;
  logic [47:0]       tx_frame;
  logic [RD_W-1:0]   resp_data_q;
  logic [CNT_W-1:0]  rx_last;
  logic              chk_end_err;
  logic              chk_crc_err;
  logic [5:0]        chk_index;
  logic [RD_W-1:0]   chk_data;

  assign tx_head  = {2'b01, cmd_index, cmd_argument};
  assign tx_frame = {tx_head, crc7_40(tx_head), 1'b1};
  assign rx_next  = {rx_sr, cmd_i};

  assign cmd_ready  = (state == IDLE);
  assign busy       = ~cmd_ready;
  assign resp_valid = (state == DONE);

`ifdef EMMC_CMD_R2_EN
  function automatic logic [6:0] crc7_120(input logic [119:0] bits);
    logic [6:0] crc;
    crc = '0;
    for (int i = 119; i >= 0; i--) crc = crc7_step(crc, bits[i]);
    return crc;
  endfunction

  logic long_rsp;
  logic unused_hdr;
  assign long_rsp  = (rtype == 2'd3);
  assign rx_last   = long_rsp ? CNT_W'(135) : CNT_W'(47);
  // The R2 start bit and reserved index field carry no information.
  assign unused_hdr = ^{rx_next[135], rx_next[133:128]};
  assign resp_data = resp_data_q;
`else
  assign rx_last   = CNT_W'(47);
  assign resp_data = {96'b0, resp_data_q};
`endif

  always_comb begin
    // NOTE: every signal driven here gets its default first, so no latch can be inferred.
    chk_end_err = ~rx_next[0] | rx_next[46];
    chk_crc_err = (rtype != 2'd2) && (crc7_40(rx_next[47:8]) != rx_next[7:1]);
    chk_index   = rx_next[45:40];
    chk_data    = RD_W'(rx_next[39:8]);
`ifdef EMMC_CMD_R2_EN
    if (long_rsp) begin
      chk_end_err = ~rx_next[0] | rx_next[134];
      chk_crc_err = (crc7_120(rx_next[127:8]) != rx_next[7:1]);
      chk_index   = '0;
      chk_data    = {rx_next[127:1], 1'b0};
    end
`endif
  end

  // NOTE: the shift registers are pure datapath, always loaded before being read, so they carry no reset.
  always_ff @(posedge mclk) begin
    if (state == IDLE && cmd_valid) tx_sr <= tx_frame[46:0];
    else if (state == SEND)         tx_sr <= {tx_sr[45:0], 1'b0};
    if (state == RECV || (state == NCR_WAIT && !cmd_i)) rx_sr <= rx_next[RX_W-2:0];
  end

  // NOTE: registers here use non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE_GUARD;
      cnt         <= '0;
      rtype       <= 2'd0;
      cmd_o       <= 1'b1;
      cmd_oe      <= 1'b0;
      resp_index  <= '0;
      resp_data_q <= '0;
      status      <= '0;
    end else begin
      unique case (state)
        IDLE_GUARD: state <= IDLE;
        IDLE: begin
          if (cmd_valid) begin
            rtype  <= resp_type;
            cmd_o  <= tx_frame[47];
            cmd_oe <= 1'b1;
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (cnt == CNT_W'(47)) begin
            cmd_oe <= 1'b0;
            cmd_o  <= 1'b1;
            cnt    <= '0;
            if (rtype == 2'd0) begin
              resp_index  <= '0;
              resp_data_q <= '0;
              status      <= 3'b000;
              state       <= DONE;
            end else begin
              state <= NCR_WAIT;
            end
          end else begin
            cmd_o <= tx_sr[46];
            cnt   <= cnt + 1'b1;
          end
        end
        NCR_WAIT: begin
          // The start bit is the first bit of the response; it counts as received.
          if (!cmd_i) begin
            cnt   <= CNT_W'(1);
            state <= RECV;
          end else if (cnt == CNT_W'(NCR_MAX - 1)) begin
            resp_index  <= '0;
            resp_data_q <= '0;
            status      <= 3'b001;
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RECV: begin
          if (cnt == rx_last) begin
            resp_index  <= chk_index;
            resp_data_q <= chk_data;
            status      <= {chk_end_err, chk_crc_err, 1'b0};
            state       <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= NCC;
        end
        NCC: begin
          if (cnt == CNT_W'(NCC_MIN - 1)) state <= IDLE;
          else                            cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE_GUARD;
      endcase
    end
  end

endmodule

// File: tb/tb_emmc_cmd_ctrl.sv
// Bench for emmc_cmd_ctrl: directed and randomized commands with a card model; expectations come from a
// frame-level reference that does CRC7 by polynomial long division.
module tb_emmc_cmd_ctrl;
  localparam int NCR_MAX = 64;
  localparam int NCC_MIN = 8;
`ifdef EMMC_CMD_R2_EN
  localparam bit R2_EN = 1'b1;
`else
  localparam bit R2_EN = 1'b0;
`endif
  localparam int GOOD = 0, FLIP = 1, END0 = 2, TRANS1 = 3;

  logic         mclk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_argument = '0;
  logic [1:0]   resp_type = '0;
  logic         cmd_i = 1'b1;
  logic         cmd_ready, cmd_o, cmd_oe, resp_valid, busy;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic [2:0]   status;

  int tests = 0;
  int fails = 0;

  always #5 mclk = ~mclk;

  emmc_cmd_ctrl #(.NCR_MAX(NCR_MAX), .NCC_MIN(NCC_MIN)) dut (
    .mclk(mclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_argument(cmd_argument), .resp_type(resp_type),
    .cmd_i(cmd_i), .cmd_o(cmd_o), .cmd_oe(cmd_oe), .resp_valid(resp_valid),
    .resp_index(resp_index), .resp_data(resp_data), .status(status), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1, message taken MSB first from v[n-1:0].
  function automatic logic [6:0] crc7_of(input logic [127:0] v, input int n);
    bit m[$];
    logic [6:0] r;
    for (int i = n - 1; i >= 0; i--) m.push_back(v[i]);
    for (int i = 0; i < 7; i++) m.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      if (m[i]) begin
        m[i] = 1'b0;
        m[i+4] = ~m[i+4];
        m[i+7] = ~m[i+7];
      end
    end
    for (int i = 0; i < 7; i++) r[6-i] = m[n+i];
    return r;
  endfunction

  // d < 0: card never answers. payload: R1/R3 status word in [31:0], R2 CID body in [119:0].
  task automatic run_txn(input string name, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] rt, input int d, input int mode,
                         input logic [119:0] payload, input bit accepted,
                         output logic [47:0] frame_seen);
    logic [39:0]  head;
    logic [47:0]  exp_cmd, got_cmd;
    logic [135:0] card_v, f;
    logic [2:0]   exp_status;
    logic [5:0]   exp_index;
    logic [127:0] exp_data;
    int card_len, len, exp_j, j, n, wait_n;
    bit oe_ok, oe_stray;

    head    = {2'b01, idx, arg};
    exp_cmd = {head, crc7_of(128'(head), 40), 1'b1};

    card_v = '0;
    if (rt == 2'd3) begin
      card_len = 136;
      card_v = {2'b00, 6'h3F, payload, crc7_of(128'(payload), 120), 1'b1};
    end else begin
      card_len = 48;
      card_v[47:0] = {2'b00, idx, payload[31:0],
                      (rt == 2'd2) ? 7'h7F : crc7_of(128'({2'b00, idx, payload[31:0]}), 40), 1'b1};
    end
    case (mode)
      FLIP:    card_v[8 + $urandom_range(0, 31)] ^= 1'b1;
      END0:    card_v[0] = 1'b0;
      TRANS1:  card_v[card_len - 2] = 1'b1;
      default: ;
    endcase

    // The controller keeps the first len bits the card sends.
    len = (R2_EN && rt == 2'd3) ? 136 : 48;
    exp_status = 3'b000;
    exp_index  = '0;
    exp_data   = '0;
    f = '0;
    if (rt == 2'd0) begin
      exp_j = 0;
    end else if (d < 0) begin
      exp_j = NCR_MAX;
      exp_status = 3'b001;
    end else begin
      f = card_v >> (card_len - len);
      exp_j = d + len;
      exp_status[2] = !f[0] || f[len-2];
      if (len == 48) begin
        exp_status[1] = (rt != 2'd2) && (crc7_of(128'(f[47:8]), 40) != f[7:1]);
        exp_index = f[45:40];
        exp_data  = 128'(f[39:8]);
      end else begin
        exp_status[1] = (crc7_of(128'(f[127:8]), 120) != f[7:1]);
        exp_data = {f[127:1], 1'b0};
      end
    end

    if (!accepted) begin
      cmd_index = idx;
      cmd_argument = arg;
      resp_type = rt;
      cmd_valid = 1'b1;
      wait_n = 0;
      while (!cmd_ready && wait_n < 200) begin
        @(negedge mclk);
        wait_n++;
      end
      check($sformatf("%s/ready", name), 128'(cmd_ready), 128'd1);
      @(negedge mclk);
      cmd_valid = 1'b0;
    end
    check($sformatf("%s/busy", name), 128'({busy, cmd_ready}), 128'd2);

    oe_ok = 1'b1;
    got_cmd = '0;
    for (int k = 0; k < 48; k++) begin
      got_cmd[47-k] = cmd_o;
      if (cmd_oe !== 1'b1) oe_ok = 1'b0;
      @(negedge mclk);
    end
    frame_seen = got_cmd;
    check($sformatf("%s/oe48", name), 128'(oe_ok), 128'd1);
    check($sformatf("%s/frame", name), 128'(got_cmd), 128'(exp_cmd));
    check($sformatf("%s/release", name), 128'({cmd_oe, cmd_o}), 128'd1);

    j = 0;
    oe_stray = 1'b0;
    while (!resp_valid && j < 400) begin
      if (cmd_oe) oe_stray = 1'b1;
      if (rt != 2'd0 && d >= 0 && j >= d && j - d < card_len) cmd_i = card_v[card_len - 1 - (j - d)];
      else cmd_i = 1'b1;
      @(negedge mclk);
      j++;
    end
    cmd_i = 1'b1;
    check($sformatf("%s/resp_valid", name), 128'(resp_valid), 128'd1);
    check($sformatf("%s/latency", name), 128'(j), 128'(exp_j));
    check($sformatf("%s/status", name), 128'(status), 128'(exp_status));
    check($sformatf("%s/index", name), 128'(resp_index), 128'(exp_index));
    check($sformatf("%s/data", name), resp_data, exp_data);
    check($sformatf("%s/no_drive", name), 128'(oe_stray), 128'd0);

    @(negedge mclk);
    check($sformatf("%s/pulse", name), 128'(resp_valid), 128'd0);
    n = 1;
    while (!cmd_ready && n < 100) begin
      @(negedge mclk);
      n++;
    end
    check($sformatf("%s/ncc", name), 128'(n), 128'(NCC_MIN + 1));
  endtask

  initial begin
    logic [47:0]  seen;
    logic [127:0] rnd;
    logic [31:0]  a;
    int wait_n;
    bit rv;

    repeat (3) @(negedge mclk);
    check("rst/ready", 128'(cmd_ready), 128'd0);
    check("rst/busy", 128'(busy), 128'd1);
    check("rst/pin", 128'({cmd_oe, cmd_o}), 128'd1);
    check("rst/outs", 128'({resp_valid, status, resp_index}), 128'd0);
    check("rst/data", resp_data, 128'd0);
    rst = 1'b0;
    #1;
    check("guard/ready0", 128'(cmd_ready), 128'd0);
    @(negedge mclk);
    check("guard/ready1", 128'(cmd_ready), 128'd1);

    run_txn("cmd0", 6'd0, 32'h0, 2'd0, 0, GOOD, 120'h0, 1'b0, seen);
    check("cmd0/literal", 128'(seen), 128'(48'h40_0000_0000_95));
    run_txn("cmd17", 6'd17, 32'h0, 2'd1, 2, GOOD, 120'h900, 1'b0, seen);
    run_txn("cmd17_flip", 6'd17, 32'h0, 2'd1, 2, FLIP, 120'h900, 1'b0, seen);
    run_txn("cmd17_end0", 6'd17, 32'h0, 2'd1, 2, END0, 120'h900, 1'b0, seen);
    run_txn("cmd17_trans", 6'd17, 32'h0, 2'd1, 2, TRANS1, 120'h900, 1'b0, seen);
    run_txn("timeout", 6'd13, $urandom(), 2'd1, -1, GOOD, 120'h0, 1'b0, seen);
    run_txn("ncr_edge", 6'd7, $urandom(), 2'd1, NCR_MAX - 1, GOOD, 120'(32'hDEAD_BEEF), 1'b0, seen);
    run_txn("ncr_zero", 6'd16, $urandom(), 2'd1, 0, GOOD, 120'(32'h0000_0200), 1'b0, seen);
    run_txn("r3", 6'd1, 32'h40FF_8080, 2'd2, 3, GOOD, 120'(32'hC0FF_8080), 1'b0, seen);
    rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_txn("r2_cid", 6'd2, 32'h0, 2'd3, 4, GOOD, rnd[119:0], 1'b0, seen);

    // Abort mid-frame: reset while bit 20 is on the pin, next request held through reset.
    cmd_index = 6'd24;
    cmd_argument = 32'h1234_5678;
    resp_type = 2'd1;
    cmd_valid = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 200) begin
      @(negedge mclk);
      wait_n++;
    end
    @(negedge mclk);
    repeat (20) @(negedge mclk);
    check("abort/oe_before", 128'(cmd_oe), 128'd1);
    a = $urandom();
    cmd_index = 6'd9;
    cmd_argument = a;
    resp_type = 2'd2;
    rst = 1'b1;
    #1;
    check("abort/pin", 128'({cmd_oe, cmd_o}), 128'd1);
    check("abort/ready", 128'(cmd_ready), 128'd0);
    rv = 1'b0;
    repeat (3) begin
      @(negedge mclk);
      if (resp_valid) rv = 1'b1;
    end
    rst = 1'b0;
    #1;
    check("abort/guard", 128'({cmd_ready, resp_valid}), 128'd0);
    @(negedge mclk);
    if (resp_valid) rv = 1'b1;
    check("abort/ready1", 128'(cmd_ready), 128'd1);
    @(negedge mclk);
    cmd_valid = 1'b0;
    check("abort/no_resp", 128'(rv), 128'd0);
    run_txn("after_abort", 6'd9, a, 2'd2, 1, GOOD, 120'(32'h80FF_8000), 1'b1, seen);

    for (int i = 0; i < 12; i++) begin
      logic [1:0] rt;
      int d;
      rt = 2'($urandom_range(0, 3));
      d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12));
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn($sformatf("rand%0d", i), 6'($urandom_range(0, 63)), $urandom(), rt, d,
              int'($urandom_range(0, 3)), rnd[119:0], 1'b0, seen);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/emmc_cmd_ctrl.md
Name: emmc_cmd_ctrl

Overview:
CMD-line controller for the eMMC socket. It accepts one command request at a time over a valid/ready handshake and serializes the 48-bit command frame with CRC7 onto the open-drain-style CMD pin (cmd_o/cmd_oe into the pad tri-state). It then waits for and deserializes the card response, checks it, and enforces NCR and NCC timing. It is the sequencer the host stack drives in place of raw send_cmd/cmd_index/cmd_argument pulses.

Parameters:
NCR_MAX, 64, max cycles from CMD release to response start bit before timeout
NCC_MIN, 8, idle cycles enforced after each transaction before cmd_ready re-asserts

Ports:
mclk  in  1  clock; all CMD bits driven and sampled on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  request present
cmd_ready  out  1  controller idle; request accepted when cmd_valid&cmd_ready at rising edge
cmd_index  in  6  command index, captured on accept
cmd_argument  in  32  argument, captured on accept
resp_type  in  2  0=none, 1=R1 (48b, CRC), 2=R3 (48b, no CRC), 3=R2 (136b)
cmd_i  in  1  CMD pin as seen by host (pulled to 1 when released)
cmd_o  out  1  CMD drive value
cmd_oe  out  1  CMD drive enable
resp_valid  out  1  one-cycle pulse: transaction finished, resp_* and status valid
resp_index  out  6  response bits [45:40] (48b types); 0 for R2/none
resp_data  out  128  48b: [31:0]=frame[39:8], upper bits 0; R2: [127:1]=frame[127:1], [0]=0
status  out  3  {end_err, crc_err, timeout}, valid with resp_valid
busy  out  1  = ~cmd_ready

Behaviour:
- Reset (async): state IDLE_GUARD, cmd_ready=0, cmd_oe=0, cmd_o=1, resp_valid=0, resp_index=0, resp_data=0, status=0. First rising edge after rst falls: cmd_ready=1.
- States: IDLE, SEND, NCR_WAIT, RECV, DONE, NCC.
- IDLE: cmd_ready=1. On accept at edge T: capture index/argument/type; cmd_ready=0, state SEND.
- SEND: frame = {0,1,index[5:0],argument[31:0],crc7[6:0],1}, MSB first. cmd_oe=1 and cmd_o=frame[47] from T+1; one bit per cycle; last bit (end bit) driven in cycle T+48; cmd_oe=0, cmd_o=1 from T+49.
- CRC7: poly x^7+x^3+1, init 0, over frame bits [47:8]; same generator used for checking.
- After SEND: resp_type 0 -> DONE. Else NCR_WAIT with cycle counter cleared.
- NCR_WAIT: counter increments per cycle; first cmd_i==0 sample is response bit 47 (start) -> RECV. Counter reaching NCR_MAX without start -> timeout=1, DONE.
- RECV: shift cmd_i each cycle; total length 48 (types 1,2) or 136 (type 3), including start bit.
- Checks at end of RECV: end_err if last bit != 1 or transmission bit (second bit) != 0. crc_err: type 1 -> CRC7 over bits[47:8] vs bits[7:1]; type 3 -> CRC7 over bits[127:8] vs bits[7:1]; type 2 -> never.
- DONE: one cycle; resp_valid=1 with resp_index/resp_data/status. Type 0 and timeout: resp_index=0, resp_data=0. Then NCC.
- NCC: NCC_MIN cycles, cmd_oe=0; then IDLE. resp_valid pulse is thus NCC_MIN+1 cycles before cmd_ready.
- cmd_valid while cmd_ready=0: ignored, no queuing; requester must hold.
- Controller never drives cmd_oe outside SEND. The host must not sample the response until cmd_oe=0.
- rst mid-transaction: cmd_oe drops immediately (async); no resp_valid for the aborted command.

Optional Feature:
EMMC_CMD_R2_EN: when defined, resp_type 3 behaves as above (136-bit receive, resp_data[127:1] populated). When undefined, resp_type 3 is treated as resp_type 1 (48-bit, CRC checked), RECV counter is sized for 48 bits only, and resp_data[127:32] is tied to 0.

Test Plan:
- CMD0, arg 0x00000000, type 0 -> cmd_o stream 0x40_00000000_95 over 48 cycles from accept+1, cmd_oe=1 exactly 48 cycles, resp_valid with status=000, cmd_ready after NCC_MIN+1 more cycles.
- CMD17, arg 0x00000000, type 1; card model drives start at NCR cycle 2 with valid R1 index 17, status 0x00000900 -> resp_index=17, resp_data=0x00000900, status=000.
- Same as the previous case with one response payload bit flipped -> crc_err=1; end bit forced to 0 -> end_err=1.
- Type 1, card never responds (cmd_i=1) -> timeout=1 exactly NCR_MAX cycles after cmd_oe falls, resp_data=0.
- Type 3 (R2, EN defined), 136-bit CID with correct CRC -> resp_data[127:1] equals frame, status=000. With EN undefined, same stimulus -> 48-bit capture only.
- rst asserted at SEND bit 20 -> cmd_oe=0 same cycle, no resp_valid; cmd_valid held through reset is accepted 2 edges after release.
